// File: rtl/simon_round_ctrl_if.sv
// Round-unit and round-key-memory connections of simon_round_ctrl.
// master = the sequencer; slave = the round unit together with the key memory.
interface simon_round_ctrl_if #(
  parameter int SIMON_MAX_WORD_WIDTH = 64,
  parameter int ROUND_CNT_WIDTH      = 7
);
  logic                            key_rd;
  logic [ROUND_CNT_WIDTH-1:0]      key_addr;
  logic [SIMON_MAX_WORD_WIDTH-1:0] key_data;
  logic                            r_mode;
  logic                            r_enc_dec;
  logic [SIMON_MAX_WORD_WIDTH-1:0] r_block1;
  logic [SIMON_MAX_WORD_WIDTH-1:0] r_block2;
  logic [SIMON_MAX_WORD_WIDTH-1:0] r_key;
  logic                            r_valid;
  logic [SIMON_MAX_WORD_WIDTH-1:0] r_block1_res;
  logic [SIMON_MAX_WORD_WIDTH-1:0] r_block2_res;
  logic                            r_o_valid;

  modport master (
    output key_rd, key_addr, r_mode, r_enc_dec, r_block1, r_block2, r_key, r_valid,
    input  key_data, r_block1_res, r_block2_res, r_o_valid
  );

  modport slave (
    input  key_rd, key_addr, r_mode, r_enc_dec, r_block1, r_block2, r_key, r_valid,
    output key_data, r_block1_res, r_block2_res, r_o_valid
  );
endinterface

// File: rtl/simon_round_ctrl.sv
// simon_round_ctrl: multi-round SIMON sequencer driving a single-round unit and a round-key memory.
// Define SIMON_CTRL_ABORT_EN to add the abort input and the DRAIN state.
module simon_round_ctrl #(
  parameter int SIMON_MAX_WORD_WIDTH = 64,
  parameter int ROUND_CNT_WIDTH      = 7
) (
  input  logic                            ck,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            mode,
  input  logic                            enc_dec,
  input  logic [SIMON_MAX_WORD_WIDTH-1:0] block1_in,
  input  logic [SIMON_MAX_WORD_WIDTH-1:0] block2_in,
`ifdef SIMON_CTRL_ABORT_EN
  input  logic                            abort,
`endif
  output logic [SIMON_MAX_WORD_WIDTH-1:0] block1_out,
  output logic [SIMON_MAX_WORD_WIDTH-1:0] block2_out,
  output logic                            busy,
  output logic                            done,
  simon_round_ctrl_if.master              bus
);

  localparam logic [ROUND_CNT_WIDTH-1:0] LAST_64  = ROUND_CNT_WIDTH'(43);
  localparam logic [ROUND_CNT_WIDTH-1:0] LAST_128 = ROUND_CNT_WIDTH'(67);
  localparam logic [SIMON_MAX_WORD_WIDTH-1:0] LOW_MASK =
    {{(SIMON_MAX_WORD_WIDTH-32){1'b0}}, {32{1'b1}}};

`ifdef SIMON_CTRL_ABORT_EN
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;
`endif

  state_t                          state_q, state_d;
  logic [ROUND_CNT_WIDTH-1:0]      round_q;
  logic                            mode_q, enc_q;
  logic [SIMON_MAX_WORD_WIDTH-1:0] blk1_q, blk2_q;
  logic [SIMON_MAX_WORD_WIDTH-1:0] out1_q, out2_q;
  logic                            done_q;

  logic                            abort_req;
  logic [ROUND_CNT_WIDTH-1:0]      last_round;
  logic                            is_last;
  logic                            accept;
  logic                            round_ack;
  logic                            final_ack;
  logic [SIMON_MAX_WORD_WIDTH-1:0] load_mask;
  logic [ROUND_CNT_WIDTH-1:0]      key_idx;
  logic [ROUND_CNT_WIDTH-1:0]      key_addr_c;
  logic                            key_rd_c;

`ifdef SIMON_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_round = mode_q ? LAST_128 : LAST_64;
  assign is_last    = (round_q == last_round);
  assign accept     = (state_q == IDLE) && start;
  // A result returning together with an abort is discarded like any drained one.
  assign round_ack  = (state_q == WAIT) && bus.r_o_valid && !abort_req;
  assign final_ack  = round_ack && is_last;
  assign load_mask  = mode ? '1 : LOW_MASK;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: state_d = abort_req ? IDLE : ISSUE;
      ISSUE: state_d = abort_req ? IDLE : WAIT;
      WAIT: begin
        if (bus.r_o_valid) begin
          state_d = (abort_req || is_last) ? IDLE : ISSUE;
        end
`ifdef SIMON_CTRL_ABORT_EN
        else if (abort_req) begin
          state_d = DRAIN;
        end
`endif
      end
`ifdef SIMON_CTRL_ABORT_EN
      DRAIN: if (bus.r_o_valid) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Round 0's key is read in FETCH; every ISSUE but the last prefetches the next round's key.
  always_comb begin
    key_rd_c   = 1'b0;
    key_idx    = '0;
    key_addr_c = '0;
    if (state_q == FETCH) begin
      key_rd_c = 1'b1;
    end else if (state_q == ISSUE && !is_last) begin
      key_rd_c = 1'b1;
      key_idx  = round_q + ROUND_CNT_WIDTH'(1);
    end
    if (key_rd_c) begin
      key_addr_c = enc_q ? key_idx : (last_round - key_idx);
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      mode_q  <= 1'b0;
      enc_q   <= 1'b0;
      blk1_q  <= '0;
      blk2_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= final_ack;
      if (accept) begin
        mode_q  <= mode;
        enc_q   <= enc_dec;
        round_q <= '0;
        blk1_q  <= block1_in & load_mask;
        blk2_q  <= block2_in & load_mask;
      end else if (round_ack) begin
        blk1_q  <= bus.r_block1_res;
        blk2_q  <= bus.r_block2_res;
        round_q <= is_last ? '0 : round_q + ROUND_CNT_WIDTH'(1);
        if (is_last) begin
          out1_q <= bus.r_block1_res;
          out2_q <= bus.r_block2_res;
        end
      end
    end
  end

  assign bus.key_rd    = key_rd_c;
  assign bus.key_addr  = key_addr_c;
  assign bus.r_mode    = mode_q;
  assign bus.r_enc_dec = enc_q;
  assign bus.r_block1  = blk1_q;
  assign bus.r_block2  = blk2_q;
  assign bus.r_key     = bus.key_data;
  assign bus.r_valid   = (state_q == ISSUE);

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign block1_out = out1_q;
  assign block2_out = out2_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: emulates the round unit and key memory, checks against a whole-cipher SIMON model.
// Abort/drain checks are compiled when SIMON_CTRL_ABORT_EN is defined.
module tb_simon_round_ctrl;

  logic        ck = 1'b0;
  logic        rst, start, mode, enc_dec;
  logic [63:0] block1_in, block2_in, block1_out, block2_out;
  logic        busy, done;
`ifdef SIMON_CTRL_ABORT_EN
  logic        abort;
`endif

  simon_round_ctrl_if bus ();

  simon_round_ctrl dut (
    .ck(ck), .rst(rst), .start(start), .mode(mode), .enc_dec(enc_dec),
    .block1_in(block1_in), .block2_in(block2_in),
`ifdef SIMON_CTRL_ABORT_EN
    .abort(abort),
`endif
    .block1_out(block1_out), .block2_out(block2_out),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap_err = 0;
  bit rand_delay = 1'b0;
  int fixed_cd = 0;

  logic [61:0] z2_seq = 62'b10101111011100000011010010011000101000010001111110010110110011;
  logic [61:0] z3_seq = 62'b11011011101011000110010111100000010010001010011100110100001111;
  logic [63:0] ks [0:1][0:67];
  logic [6:0]  addr_q [$];

  typedef struct {
    bit          m;
    bit          e;
    logic [63:0] b1, b2, x1, x2;
    int          cyc;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [63:0] rol(input logic [63:0] v, input int s, input bit w);
    logic [31:0] h;
    if (w) return (v << s) | (v >> (64 - s));
    h = v[31:0];
    return {32'h0, (h << s) | (h >> (32 - s))};
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int s, input bit w);
    return rol(v, (w ? 64 : 32) - s, w);
  endfunction

  function automatic logic [63:0] sf(input logic [63:0] v, input bit w);
    return (rol(v, 1, w) & rol(v, 8, w)) ^ rol(v, 2, w);
  endfunction

  task automatic expand(input bit w, input logic [63:0] k0, k1, k2, k3);
    int m = w ? 2 : 4;
    int t = w ? 68 : 44;
    logic [63:0] mask = w ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    logic [63:0] tmp;
    logic        zb;
    ks[w][0] = k0 & mask; ks[w][1] = k1 & mask;
    ks[w][2] = k2 & mask; ks[w][3] = k3 & mask;
    for (int i = m; i < t; i++) begin
      tmp = ror(ks[w][i-1], 3, w);
      if (m == 4) tmp = tmp ^ ks[w][i-3];
      tmp = tmp ^ ror(tmp, 1, w);
      zb  = w ? z2_seq[61 - ((i - m) % 62)] : z3_seq[61 - ((i - m) % 62)];
      ks[w][i] = (~ks[w][i-m] ^ tmp ^ {63'h0, zb} ^ 64'd3) & mask;
    end
  endtask

  // Whole-cipher reference: all rounds applied in one go with the expanded key table.
  function automatic logic [127:0] simon_ref(input bit w, input bit e, input logic [63:0] x0, y0);
    logic [63:0] mask = w ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    logic [63:0] x = x0 & mask;
    logic [63:0] y = y0 & mask;
    logic [63:0] t;
    int nr = w ? 68 : 44;
    if (e) for (int r = 0; r < nr; r++) begin t = x; x = (y ^ sf(x, w) ^ ks[w][r]) & mask; y = t; end
    else   for (int r = nr - 1; r >= 0; r--) begin t = y; y = (x ^ sf(y, w) ^ ks[w][r]) & mask; x = t; end
    return {x, y};
  endfunction

  function automatic logic [127:0] one_round(input bit w, input bit e, input logic [63:0] x, y, k);
    logic [63:0] mask = w ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    if (e) return {(y ^ sf(x, w) ^ k) & mask, x};
    return {y, (x ^ sf(y, w) ^ k) & mask};
  endfunction

  // Round-unit stand-in: one result, 2 or more cycles after r_valid.
  bit pend = 1'b0;
  int cd = 0;
  always @(posedge ck) begin
    bus.r_o_valid <= 1'b0;
    if (rst) begin
      pend <= 1'b0;
      bus.r_block1_res <= '0;
      bus.r_block2_res <= '0;
    end else begin
      if (pend) begin
        if (cd == 0) begin bus.r_o_valid <= 1'b1; pend <= 1'b0; end
        else cd <= cd - 1;
      end
      if (bus.r_valid) begin
        if (pend) overlap_err <= overlap_err + 1;
        pend <= 1'b1;
        cd   <= rand_delay ? int'($urandom_range(0, 3)) : fixed_cd;
        {bus.r_block1_res, bus.r_block2_res} <=
          one_round(bus.r_mode, bus.r_enc_dec, bus.r_block1, bus.r_block2, bus.r_key);
      end
    end
  end

  always @(posedge ck) begin
    if (rst) bus.key_data <= '0;
    else if (bus.key_rd) begin
      if (int'(bus.key_addr) < (bus.r_mode ? 68 : 44))
        bus.key_data <= ks[int'(bus.r_mode)][int'(bus.key_addr)];
      else
        bus.key_data <= 64'hbad0_bad0_bad0_bad0;
      addr_q.push_back(bus.key_addr);
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  function automatic int addr_errors(input bit m, input bit e);
    int nr = m ? 68 : 44;
    int errs = 0;
    if (addr_q.size() != nr) errs++;
    for (int i = 0; i < addr_q.size() && i < nr; i++)
      if (int'(addr_q[i]) != (e ? i : nr - 1 - i)) errs++;
    return errs;
  endfunction

  task automatic applyStimulus(input bit m, input bit e, input logic [63:0] b1, b2);
    mode = m; enc_dec = e; block1_in = b1; block2_in = b2; start = 1'b1;
    addr_q.delete();
    @(posedge ck);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int poke, input logic [6:0] exp_a0,
                           output int cyc, output bit got, output int busy_err, output bit fetch_ok);
    cyc = 1; got = 0; busy_err = 0; fetch_ok = 0;
    while (cyc <= budget) begin
      @(negedge ck);
      start = (cyc == poke);
      if (cyc == poke) begin block1_in = ~block1_in; mode = ~mode; end
      if (cyc == 1) fetch_ok = busy && bus.key_rd && !bus.r_valid && (bus.key_addr == exp_a0);
      if (done) begin got = 1; if (busy) busy_err++; break; end
      if (!busy) busy_err++;
      @(posedge ck);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic run_vec(input string tag, input bit m, input bit e, input logic [63:0] b1, b2, x1, x2,
                         input int exp_cyc, input int poke);
    int cyc, busy_err;
    bit got, fetch_ok;
    applyStimulus(m, e, b1, b2);
    wait_done(1000, poke, e ? 7'd0 : (m ? 7'd67 : 7'd43), cyc, got, busy_err, fetch_ok);
    checkOutput({tag, " done seen"}, got, 1);
    if (exp_cyc > 0) checkOutput({tag, " done cycle"}, cyc, exp_cyc);
    checkOutput({tag, " result"}, {block1_out, block2_out}, {x1, x2});
    checkOutput({tag, " busy profile errors"}, busy_err, 0);
    checkOutput({tag, " fetch after start"}, fetch_ok, 1);
    checkOutput({tag, " key_addr seq errors"}, addr_errors(m, e), 0);
  endtask

  task automatic check_idle_zero(input string tag);
    checkOutput({tag, " ctrl outputs"},
                {busy, done, bus.key_rd, bus.key_addr, bus.r_valid, bus.r_mode, bus.r_enc_dec}, '0);
    checkOutput({tag, " round blocks"}, {bus.r_block1, bus.r_block2}, '0);
    checkOutput({tag, " result blocks"}, {block1_out, block2_out}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          dseen;
    logic [63:0] rb1, rb2;
    logic [127:0] exp;
    bit          rm, re;
    rst = 1'b1; start = 1'b0; mode = 1'b0; enc_dec = 1'b0;
    block1_in = '0; block2_in = '0;
`ifdef SIMON_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    expand(1'b0, 64'h03020100, 64'h0b0a0908, 64'h13121110, 64'h1b1a1918);
    expand(1'b1, 64'h0706050403020100, 64'h0f0e0d0c0b0a0908, 64'h0, 64'h0);

    vecs[0] = '{1'b0, 1'b1, 64'h656b696c, 64'h20646e75, 64'h44c8fc20, 64'hb9dfa07a, 134};
    vecs[1] = '{1'b0, 1'b0, 64'h44c8fc20, 64'hb9dfa07a, 64'h656b696c, 64'h20646e75, 134};
    vecs[2] = '{1'b1, 1'b1, 64'h6373656420737265, 64'h6c6c657661727420,
                64'h49681b1e1e54fe3f, 64'h65aa832af84e0bbc, 206};
    vecs[3] = '{1'b1, 1'b0, 64'h49681b1e1e54fe3f, 64'h65aa832af84e0bbc,
                64'h6373656420737265, 64'h6c6c657661727420, 206};
    vecs[4] = '{1'b0, 1'b1, 64'hffffffff_656b696c, 64'h12345678_20646e75,
                64'h44c8fc20, 64'hb9dfa07a, 134};

    repeat (3) @(posedge ck);
    @(negedge ck);
    check_idle_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      run_vec($sformatf("vec%0d", i), vecs[i].m, vecs[i].e, vecs[i].b1, vecs[i].b2,
              vecs[i].x1, vecs[i].x2, vecs[i].cyc, -1);
    end

    // start pulsed mid-run is ignored; start in the done cycle launches the next op
    @(negedge ck);
    run_vec("busy start", 1'b0, 1'b1, 64'h656b696c, 64'h20646e75, 64'h44c8fc20, 64'hb9dfa07a, 134, 50);
    run_vec("done start", 1'b0, 1'b0, 64'h44c8fc20, 64'hb9dfa07a, 64'h656b696c, 64'h20646e75, 134, -1);

    // reset while round 20 is being issued
    @(negedge ck);
    applyStimulus(1'b0, 1'b1, 64'h656b696c, 64'h20646e75);
    repeat (61) @(posedge ck);
    #1;
    checkOutput("round 20 issue", bus.r_valid, 1);
    rst = 1'b1;
    @(posedge ck);
    #1 rst = 1'b0;
    @(negedge ck);
    check_idle_zero("mid-op rst");
    dseen = 0;
    repeat (20) begin @(negedge ck); if (done || busy) dseen = 1; end
    checkOutput("activity after rst", dseen, 0);
    @(negedge ck);
    run_vec("post rst", 1'b0, 1'b1, 64'h656b696c, 64'h20646e75, 64'h44c8fc20, 64'hb9dfa07a, 134, -1);

`ifdef SIMON_CTRL_ABORT_EN
    // abort in WAIT of round 0 with a slow round unit: busy must cover the drain
    fixed_cd = 3;
    @(negedge ck);
    applyStimulus(1'b1, 1'b1, 64'h1, 64'h2);
    @(posedge ck);
    @(posedge ck);
    #1 abort = 1'b1;
    @(posedge ck);
    #1 abort = 1'b0;
    dseen = 0;
    repeat (4) begin @(negedge ck); if (!busy || done || bus.r_valid) dseen = 1; end
    checkOutput("drain busy", dseen, 0);
    @(negedge ck);
    checkOutput("after drain busy/done", {busy, done}, 2'b00);
    checkOutput("abort keeps result", {block1_out, block2_out}, {64'h44c8fc20, 64'hb9dfa07a});
    fixed_cd = 0;
    dseen = 0;
    repeat (10) begin @(negedge ck); if (done || busy) dseen = 1; end
    checkOutput("no done after abort", dseen, 0);
    @(negedge ck);
    run_vec("post abort", 1'b1, 1'b1, 64'h6373656420737265, 64'h6c6c657661727420,
            64'h49681b1e1e54fe3f, 64'h65aa832af84e0bbc, 206, -1);
`endif

    // random blocks, modes and round-unit latencies against the whole-cipher model
    rand_delay = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rm  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      rb1 = {$urandom, $urandom};
      rb2 = {$urandom, $urandom};
      exp = simon_ref(rm, re, rb1, rb2);
      @(negedge ck);
      run_vec($sformatf("rand%0d", i), rm, re, rb1, rb2, exp[127:64], exp[63:0], 0, -1);
    end
    rand_delay = 1'b0;

    repeat (8) @(posedge ck);
    checkOutput("round overlap count", overlap_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
